// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned PC_STEP     = 4;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [DefaultXlen-1:0] pc;
    logic [DefaultXlen-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-to-decode handshake: (pc, instruction) pairs under valid/ready.
interface fetch_sequencer_if import fetch_pkg::*; #(
  parameter int unsigned XLEN = DefaultXlen
) ();

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instruction;

  modport master (
    output valid,
    output pc,
    output instruction,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  instruction,
    output ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO holding fetched (pc, instruction) entries; synchronous flush
// clears pointers and count but leaves stale data in place.
module fetch_buffer import fetch_pkg::*; #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = $bits(fetch_entry_t),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq,
  input  logic [Width-1:0] enq_data,
  input  logic             deq,
  output logic [Width-1:0] head_data,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (enq) wr_d = ptr_inc(wr_q);
      if (deq) rd_d = ptr_inc(rd_q);
      case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (enq && !flush) mem_q[wr_q] <= enq_data;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;

  // The issue rule upstream must make this impossible.
  enq_into_full_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(enq && count_q == CntW'(Depth)));

endmodule

// File: rtl/fetch_sequencer.sv
// Issues sequential fetches to a 1-cycle-latency instruction memory, buffers
// returned words and hands them to decode; supports redirect and halt.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int unsigned     XLEN      = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            btn_reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  fetch_sequencer_if.master out,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [XLEN-1:0]   inflight_pc_q;
  logic [CntW-1:0]   count;
  logic [OccW-1:0]   occupancy;
  logic [2*XLEN-1:0] head_data;
  logic              deq, enq, issue;

  assign deq = out.valid & out.ready;
  // A redirect squashes the word returning this cycle.
  assign enq = inflight_q & ~redirect_valid;

  // Slots claimed after this cycle: buffered plus in flight, minus the word leaving.
  assign occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(deq);
  assign issue = (state_q == StRun) & ~halt & ~redirect_valid &
                 (occupancy < OccW'(BUF_DEPTH));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (halt && !redirect_valid) state_d = StHalt;
      StHalt:  if (!halt) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!btn_reset) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  fetch_buffer #(
    .Depth(BUF_DEPTH),
    .Width(2 * XLEN)
  ) u_buffer (
    .clk      (clk),
    .rst_n    (btn_reset),
    .flush    (redirect_valid),
    .enq      (enq),
    .enq_data ({inflight_pc_q, imem_instruction}),
    .deq      (deq),
    .head_data(head_data),
    .count    (count)
  );

  assign imem_pc         = fetch_pc_q;
  assign out.valid       = (count != '0);
  assign out.pc          = head_data[2*XLEN-1:XLEN];
  assign out.instruction = head_data[XLEN-1:0];
  assign busy            = (count != '0) | inflight_q;

endmodule
